// File: rtl/mult_iter.sv
// Iterative radix-2 shift-add multiplier producing a full 2*WIDTH-bit product.
// Signed operands are multiplied as magnitudes and the product negated at the end.
module mult_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]           state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    mag_a    = (sign && a[WIDTH-1]) ? -a : a;
    mag_b    = (sign && b[WIDTH-1]) ? -b : b;
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= CALC;
            count  <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= neg ? -acc_next : acc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_iter.sv
// Randomized and directed bench for mult_iter at WIDTH=32, checked against
// a plain 64-bit arithmetic reference.
module tb_mult_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic           sign;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  mult_iter #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .sign(sign),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Sign-extend (or zero-extend) to 2W bits; the product mod 2^(2W) is the exact answer.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] ex, ey;
    ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return ex * ey;
  endfunction

  // Driver: issue one operation, then watch until done (bounded).
  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [2*W-1:0] res, output int lat, output int bcnt,
                        output bit bad);
    logic [2*W-1:0] held;
    @(negedge clk);
    start = 1'b1; sign = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
    lat = 1; bcnt = 0; bad = 1'b0; held = result;
    while (!done && lat < 100) begin
      bcnt += int'(busy);
      if (busy && done) bad = 1'b1;
      if (result !== held) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (busy && done) bad = 1'b1;
    res = result;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; sign = 1'b0; a = 32'd5; b = 32'd7;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    vectors++;
    if (result !== '0) begin
      miscompares++;
      $display("FAIL reset_result got=%h expected 0", result);
    end
    start = 1'b0; rstn = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic check_op(input string name, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] res, exp;
    int lat, bcnt;
    bit bad;
    exp = model(s, x, y);
    run_op(s, x, y, res, lat, bcnt, bad);
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL %s_result s=%b a=%h b=%h got=%h expected %h", name, s, x, y, res, exp);
    end
    vectors++;
    if (lat != W + 1 || bcnt != W) begin
      miscompares++;
      $display("FAIL %s_timing latency=%0d busy_cycles=%0d expected %0d %0d", name, lat, bcnt, W + 1, W);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s_flags busy/done overlap or result moved during calc: 1 expected 0", name);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || result !== exp) begin
      miscompares++;
      $display("FAIL %s_after done=%b result=%h expected 0 %h", name, done, result, exp);
    end
  endtask

  task automatic test_directed();
    logic         ts [8];
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    ta = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF};
    tb = '{32'd3, 32'd3, 32'd7, 32'd1, 32'h80000000, 32'd12345, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) check_op($sformatf("directed%0d", i), ts[i], ta[i], tb[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      check_op($sformatf("random%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_back_to_back();
    int n, ndone, t0, t1;
    logic [2*W-1:0] r0, r1;
    n = 0; ndone = 0; t0 = 0; t1 = 0; r0 = '0; r1 = '0;
    @(negedge clk);
    start = 1'b1; sign = 1'b0; a = 32'd55; b = 32'd3;
    while (ndone < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (ndone == 0) begin t0 = n; r0 = result; end
        else begin t1 = n; r1 = result; start = 1'b0; end
        ndone++;
      end
    end
    start = 1'b0;
    vectors++;
    if (ndone != 2 || t0 != W + 1 || t1 - t0 != W + 1) begin
      miscompares++;
      $display("FAIL b2b_timing pulses=%0d first=%0d gap=%0d expected 2 %0d %0d", ndone, t0, t1 - t0, W + 1, W + 1);
    end
    vectors++;
    if (r0 !== 64'hA5 || r1 !== 64'hA5) begin
      miscompares++;
      $display("FAIL b2b_result got=%h %h expected a5 a5", r0, r1);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1; sign = 1'b0; a = 32'd55; b = 32'd3;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (9) begin @(negedge clk); lat++; end
    start = 1'b1; sign = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    lat++;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_busy got=%b expected 1", busy);
    end
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    vectors++;
    if (lat != W + 1 || result !== 64'hA5) begin
      miscompares++;
      $display("FAIL ignore_start latency=%0d result=%h expected %0d a5", lat, result, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    logic [2*W-1:0] res;
    int lat, bcnt, pulses;
    bit bad;
    @(negedge clk);
    start = 1'b1; sign = 1'b0; a = 32'd55; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      miscompares++;
      $display("FAIL midreset_state busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    pulses = 0;
    repeat (40) begin @(negedge clk); pulses += int'(done); end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL midreset_nodone pulses=%0d expected 0", pulses);
    end
    run_op(1'b1, 32'hFFFFFFF9, 32'd6, res, lat, bcnt, bad);
    vectors++;
    if (res !== model(1'b1, 32'hFFFFFFF9, 32'd6) || lat != W + 1) begin
      miscompares++;
      $display("FAIL midreset_restart result=%h latency=%0d expected %h %0d",
               res, lat, model(1'b1, 32'hFFFFFFF9, 32'd6), W + 1);
    end
  endtask

  initial begin
    start = 1'b0; sign = 1'b0; a = '0; b = '0; rstn = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_iter.md
MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
REQ-005 sign  input  1  1 = signed (two's complement) multiply, 0 = unsigned; captured with start.
REQ-006 a  input  WIDTH  multiplicand; captured with start.
REQ-007 b  input  WIDTH  multiplier; captured with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse when result becomes valid.
REQ-010 result  output  2*WIDTH  full-width product.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-012 In IDLE or DONE, a rising edge with start=1 SHALL capture a, b and sign, enter CALC, clear the iteration counter, and set busy=1.
REQ-013 In signed mode, the captured operands SHALL be converted to magnitudes, and a negate flag SHALL be recorded as sign_a XOR sign_b.
REQ-014 In unsigned mode, the operands SHALL be used as-is, with the negate flag = 0.
REQ-015 CALC SHALL perform one radix-2 shift-add step per cycle for exactly WIDTH cycles, using a 2*WIDTH-bit accumulator with no truncation.
REQ-016 On the edge that completes the WIDTH-th step, the FSM SHALL enter DONE.
REQ-017 On that same edge, result SHALL be loaded with the accumulator, negated mod 2^(2*WIDTH) if the negate flag is set.
REQ-018 On that same edge, busy SHALL fall and done SHALL rise.
REQ-019 Latency SHALL be WIDTH+1 rising edges from the start-accept edge to the edge that raises done; busy SHALL be high for exactly WIDTH cycles.
REQ-020 done SHALL be high for exactly one cycle (the DONE state); DONE SHALL return to IDLE on the next edge unless start=1.
REQ-021 With start=1 in DONE, the FSM SHALL go directly to CALC (back-to-back operation, no idle bubble).
REQ-022 start, a, b and sign SHALL be ignored while in CALC; the in-flight operation SHALL be unaffected.
REQ-023 result SHALL hold its value from the DONE edge until the next DONE edge; it SHALL NOT change during CALC.
REQ-024 The signed most-negative operand (1 followed by WIDTH-1 zeros) SHALL be handled exactly; its magnitude is 2^(WIDTH-1) in WIDTH unsigned bits.
REQ-025 A zero operand SHALL still take the full latency; there is no early termination.
REQ-026 busy and done SHALL never be high in the same cycle.

Reset
REQ-027 rstn=0 at a rising edge SHALL force the FSM to IDLE and clear the iteration counter.
REQ-028 rstn=0 at a rising edge SHALL clear the internal operand and accumulator registers.
REQ-029 rstn=0 at a rising edge SHALL set busy=0, done=0 and result=0, regardless of state, including mid-CALC.
REQ-030 A start asserted on an edge where rstn=0 SHALL be ignored.
REQ-031 After rstn returns high, the block SHALL accept start on the next edge.

Verification (WIDTH=32)
REQ-032 sign=0, a=0xFFFFFFFF, b=3, start for 1 cycle -> busy high for 32 cycles, then done pulse; result=0x00000002_FFFFFFFD.
REQ-033 sign=1, a=0xFFFFFFFF (-1), b=3 -> result=0xFFFFFFFF_FFFFFFFD; sign=1, a=0xFFFFFFFE (-2), b=7 -> result=0xFFFFFFFF_FFFFFFF2.
REQ-034 sign=1, a=0x80000000, b=1 -> result=0xFFFFFFFF_80000000; sign=1, a=b=0x80000000 -> result=0x40000000_00000000.
REQ-035 sign=0, a=55, b=3, with start held high through DONE -> back-to-back operations, both result=0x00000000_000000A5, done pulses exactly 33 cycles apart.
REQ-036 Start a=55, b=3, then pulse start with a=9, b=9 at CALC cycle 10 -> second request ignored, result=0xA5.
REQ-037 Start a=55, b=3, then pulse rstn=0 at CALC cycle 10 -> busy=0, done=0, result=0, and no done pulse ever follows.
